// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq: sequential modular add/subtract, (A+B) mod Q or (A-B) mod Q.
// One 3:2 CSA compression, then chunked carry/borrow resolution.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_in_valid / o_in_ready   request handshake (ready only when idle)
//   i_op                      0 = add, 1 = subtract
//   i_a, i_b                  operands, WIDTH bits, expected < Q
//   o_out_valid / i_out_ready result handshake
//   o_result                  reduced result, WIDTH bits
//   o_done_cnt                completed transactions (saturating)
//
// Build option: define MODSEQ_PERF_EN to enable the o_done_cnt counter;
// without it o_done_cnt is tied to zero.

module mod_addsub_seq #(
  parameter int WIDTH = 255,
  parameter int CHUNK_W = 64,
  parameter logic [WIDTH-1:0] Q = {WIDTH{1'b1}} - WIDTH'(18)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [15:0]      o_done_cnt
);

  localparam int NCHUNK = (WIDTH + CHUNK_W) / CHUNK_W;
  localparam int PW = NCHUNK * CHUNK_W;
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // position of bit WIDTH inside the most significant chunk
  localparam int LAST_MSB = WIDTH - (NCHUNK - 1) * CHUNK_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [PW-1:0] Q_PAD = PW'(Q);
  localparam logic [CHUNK_W-1:0] TOP_MASK =
    {CHUNK_W{1'b1}} >> (CHUNK_W - 1 - LAST_MSB);
  localparam logic [CHUNK_W-1:0] TOP_BIT = CHUNK_W'(1) << LAST_MSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSA  = 2'd1,
    RES  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             cin_q, cin_d;

  logic [PW-1:0] sum_q, sum_d;
  logic [PW-1:0] cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic borrow_q, borrow_d;

  // X and X-Q are assembled LSB chunk first by shifting in from the top
  logic [PW-1:0] x_q, x_d;
  logic [PW-1:0] dif_q, dif_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;

  // carry-save compression of (A, B', C)
  logic [WIDTH-1:0] csa_c;
  logic [WIDTH-1:0] csa_s;
  logic [WIDTH-1:0] csa_m;

  assign csa_c = op_q ? Q : '0;
  assign csa_s = a_q ^ b_q ^ csa_c;
  assign csa_m = (a_q & b_q) | (a_q & csa_c) | (b_q & csa_c);

  // per-chunk resolution
  logic               last_chk;
  logic [CHUNK_W:0]   x_raw;
  logic [CHUNK_W-1:0] x_chk;
  logic [CHUNK_W-1:0] q_chk;
  logic [CHUNK_W:0]   d_raw;

  assign last_chk = (cnt_q == LAST_CNT);

  assign x_raw = {1'b0, sum_q[CHUNK_W-1:0]}
               + {1'b0, cout_q[CHUNK_W-1:0]}
               + {{CHUNK_W{1'b0}}, carry_q};

  always_comb begin
    q_chk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        q_chk = Q_PAD[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  // Top chunk: drop bits above WIDTH (mod 2^(WIDTH+1)) and, for
  // subtract, flip bit WIDTH to cancel the 2^WIDTH from ~B + 1.
  always_comb begin
    x_chk = x_raw[CHUNK_W-1:0];
    if (last_chk) begin
      x_chk = (x_chk & TOP_MASK) ^ (op_q ? TOP_BIT : '0);
    end
  end

  assign d_raw = {1'b0, x_chk}
               - {1'b0, q_chk}
               - {{CHUNK_W{1'b0}}, borrow_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    x_d         = x_q;
    dif_d       = dif_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (i_in_valid) begin
          a_d     = i_a;
          b_d     = i_op ? ~i_b : i_b;
          op_d    = i_op;
          cin_d   = i_op;
          state_d = CSA;
        end
      end
      CSA: begin
        sum_d              = '0;
        sum_d[WIDTH-1:0]   = csa_s;
        cout_d             = '0;
        cout_d[WIDTH:1]    = csa_m;
        carry_d            = cin_q;
        borrow_d           = 1'b0;
        cnt_d              = '0;
        state_d            = RES;
      end
      RES: begin
        sum_d    = sum_q >> CHUNK_W;
        cout_d   = cout_q >> CHUNK_W;
        carry_d  = x_raw[CHUNK_W];
        borrow_d = d_raw[CHUNK_W];
        x_d      = x_q >> CHUNK_W;
        x_d[PW-1 -: CHUNK_W]   = x_chk;
        dif_d    = dif_q >> CHUNK_W;
        dif_d[PW-1 -: CHUNK_W] = d_raw[CHUNK_W-1:0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_chk) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // first DONE cycle picks X or X-Q; result is then held
        if (!out_valid_q) begin
          res_d       = borrow_q ? x_q[WIDTH-1:0] : dif_q[WIDTH-1:0];
          out_valid_d = 1'b1;
        end else if (i_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      x_q         <= '0;
      dif_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      x_q         <= x_d;
      dif_q       <= dif_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_in_ready  = (state_q == IDLE);
  assign o_out_valid = out_valid_q;
  assign o_result    = res_q;

`ifdef MODSEQ_PERF_EN
  logic        done_inc;
  logic [15:0] done_cnt_q, done_cnt_d;

  assign done_inc = (state_q == DONE) && out_valid_q && i_out_ready;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (done_inc && (done_cnt_q != 16'hFFFF)) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign o_done_cnt = done_cnt_q;
`else
  assign o_done_cnt = '0;
`endif

endmodule

// File: tb/tb_mod_addsub_seq.sv
// tb_mod_addsub_seq: scoreboard bench for mod_addsub_seq at default params.
// Expected results are queued at request time and popped at the handshake.

module tb_mod_addsub_seq;

  localparam int W = 255;
  localparam logic [W:0] Q_WIDE = (256'd1 << 255) - 256'd19;
  localparam logic [W-1:0] QT = Q_WIDE[W-1:0];

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [15:0]  done_cnt;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  mod_addsub_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0] t;
    if (o == 1'b0) begin
      t = {1'b0, x} + {1'b0, y};
      if (t >= Q_WIDE) t = t - Q_WIDE;
    end else if (x >= y) begin
      t = {1'b0, x} - {1'b0, y};
    end else begin
      t = {1'b0, x} + Q_WIDE - {1'b0, y};
    end
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    logic [W:0] v;
    v = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    v[W] = 1'b0;
    if (v >= Q_WIDE) v = v - Q_WIDE;
    return v[W-1:0];
  endfunction

  // one transaction: request, latency check, optional backpressure
  // window (optionally with a competing request), then handshake
  task automatic run_txn(input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e,
                         input int hold, input bit inject);
    int lat;
    int w;
    logic [W-1:0] held;
    logic [W-1:0] want;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: in_ready=%0b required 1", in_ready);
      return;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL latency: got %0d cycles required 6", lat);
    end
    if (!out_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      if (inject) begin
        in_valid = 1'b1;
        op = ~o;
        a = y;
        b = x;
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) begin
        bad++;
        $display("FAIL hold_%0d: valid=%0b ready=%0b result=%h required valid=1 ready=0 result=%h",
                 i, out_valid, in_ready, result, held);
      end
    end
    in_valid = 1'b0;
    want = exp_q.pop_front();
    total++;
    if (result !== want) begin
      bad++;
      $display("FAIL result op=%0b: got %h required %h", o, result, want);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release: valid=%0b ready=%0b required valid=0 ready=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        result !== '0 || done_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: ready=%0b valid=%0b result=%h cnt=%0d required 1 0 0 0",
               in_ready, out_valid, result, done_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(1'b0, QT - 1, 255'd1, 255'd0, 0, 1'b0);
    run_txn(1'b1, 255'd0, 255'd1, QT - 1, 0, 1'b0);
    run_txn(1'b1, 255'd5, 255'd5, 255'd0, 0, 1'b0);
    run_txn(1'b0, 255'd2, 255'd3, 255'd5, 0, 1'b0);
    run_txn(1'b1, 255'd1, QT - 1, 255'd2, 0, 1'b0);
    run_txn(1'b0, QT - 1, QT - 1, QT - 2, 0, 1'b0);
    run_txn(1'b1, QT - 1, 255'd0, QT - 1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic o;
    for (int i = 0; i < 8; i++) begin
      x = rnd_operand();
      y = rnd_operand();
      o = 1'($urandom_range(0, 1));
      run_txn(o, x, y, model(o, x, y), 0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    run_txn(1'b0, 255'd100, QT - 50, 255'd50, 10, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL no_queue: valid seen=%0b required 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    op = 1'b1;
    a = QT - 3;
    b = 255'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        result !== '0 || done_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid: ready=%0b valid=%0b result=%h cnt=%0d required 1 0 0 0",
               in_ready, out_valid, result, done_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort: valid seen=%0b required 0", seen);
    end
    run_txn(1'b0, 255'd7, 255'd8, 255'd15, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 255'd11, 255'd22, 255'd33, 0, 1'b0);
    run_txn(1'b1, 255'd11, 255'd22, QT - 11, 0, 1'b0);
    run_txn(1'b0, QT - 4, 255'd9, 255'd5, 0, 1'b0);
`ifdef MODSEQ_PERF_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    total++;
    if (done_cnt !== want) begin
      bad++;
      $display("FAIL done_cnt: got %0d required %0d", done_cnt, want);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard: %0d results left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
